axi_lite_demux: RTL and testbench

// - 1-master -> N-slave AXI4-Lite address decoder/demux; successor to the fixed-page crossbar.
// - Programmable per-slave base/mask windows; unmapped addresses get DECERR from an internal error slave.
// - Independent read and write paths: one read and one write in flight concurrently.
// - AW/AR latched at the demux, so slave address/prot are stable for the whole transaction.

---
 rtl/axi_lite_pkg.sv | 28 ++
 rtl/axi_lite_addr_decode.sv | 29 ++
 rtl/axi_lite_demux.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_lite_demux.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared response codes and FSM state types for the AXI4-Lite demux.
//   RESP_*      : AXI response encodings as seen on bresp/rresp
//   wr_state_t  : write-path FSM states
//   rd_state_t  : read-path FSM states
package axi_lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        W_IDLE,
        W_FWD,
        W_RESP,
        W_ERRD,
        W_ERRB
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FWD,
        R_RESP,
        R_ERR
    } rd_state_t;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// axi_lite_addr_decode: combinational address-window decoder.
//   addr : address to classify
//   hit  : address falls inside at least one slave window
//   idx  : lowest-numbered matching slave (0 when no hit)
module axi_lite_addr_decode #(
    parameter int                     N  = 10,
    parameter int                     AW = 32,
    parameter logic [N-1:0][AW-1:0]   SLV_BASE = '0,
    parameter logic [N-1:0][AW-1:0]   SLV_MASK = '0,
    localparam int                    IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i])) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/axi_lite_demux.sv
// axi_lite_demux: 1-master to N-slave AXI4-Lite demux with programmable base/mask windows.
//   aclk, aresetn        : clock, asynchronous active-low reset
//   m_aw*/m_w*/m_b*      : upstream master write channels
//   m_ar*/m_r*           : upstream master read channels
//   s_aw*/s_w*/s_b*      : per-slave write channels, packed [N-1:0]
//   s_ar*/s_r*           : per-slave read channels, packed [N-1:0]
// Unmapped addresses are answered with DECERR by an internal error slave.
module axi_lite_demux
    import axi_lite_pkg::*;
#(
    parameter int                     N  = 10,
    parameter int                     AW = 32,
    parameter int                     DW = 32,
    parameter logic [N-1:0][AW-1:0]   SLV_BASE = '0,
    parameter logic [N-1:0][AW-1:0]   SLV_MASK = '0
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [AW-1:0]              m_awaddr,
    input  logic [2:0]                 m_awprot,
    input  logic                       m_awvalid,
    output logic                       m_awready,
    input  logic [DW-1:0]              m_wdata,
    input  logic [DW/8-1:0]            m_wstrb,
    input  logic                       m_wvalid,
    output logic                       m_wready,
    output logic [1:0]                 m_bresp,
    output logic                       m_bvalid,
    input  logic                       m_bready,
    input  logic [AW-1:0]              m_araddr,
    input  logic [2:0]                 m_arprot,
    input  logic                       m_arvalid,
    output logic                       m_arready,
    output logic [DW-1:0]              m_rdata,
    output logic [1:0]                 m_rresp,
    output logic                       m_rvalid,
    input  logic                       m_rready,
    output logic [N-1:0][AW-1:0]       s_awaddr,
    output logic [N-1:0][2:0]          s_awprot,
    output logic [N-1:0]               s_awvalid,
    input  logic [N-1:0]               s_awready,
    output logic [N-1:0][DW-1:0]       s_wdata,
    output logic [N-1:0][DW/8-1:0]     s_wstrb,
    output logic [N-1:0]               s_wvalid,
    input  logic [N-1:0]               s_wready,
    input  logic [N-1:0][1:0]          s_bresp,
    input  logic [N-1:0]               s_bvalid,
    output logic [N-1:0]               s_bready,
    output logic [N-1:0][AW-1:0]       s_araddr,
    output logic [N-1:0][2:0]          s_arprot,
    output logic [N-1:0]               s_arvalid,
    input  logic [N-1:0]               s_arready,
    input  logic [N-1:0][DW-1:0]       s_rdata,
    input  logic [N-1:0][1:0]          s_rresp,
    input  logic [N-1:0]               s_rvalid,
    output logic [N-1:0]               s_rready
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    wr_state_t     wr_state;
    rd_state_t     rd_state;
    logic [AW-1:0] awaddr_q, araddr_q;
    logic [2:0]    awprot_q, arprot_q;
    logic [IW-1:0] wsel, rsel;
    logic          aw_done, w_done;
    logic          awready_q, arready_q;
    logic          aw_hit, ar_hit;
    logic [IW-1:0] aw_idx, ar_idx;
    logic [N-1:0]  wsel_oh, rsel_oh;
    logic          aw_fire, w_fire, ar_fire;
    logic          w_fwd, aw_now, w_now;

    axi_lite_addr_decode #(
        .N        (N),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_aw_dec (
        .addr (m_awaddr),
        .hit  (aw_hit),
        .idx  (aw_idx)
    );

    axi_lite_addr_decode #(
        .N        (N),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_ar_dec (
        .addr (m_araddr),
        .hit  (ar_hit),
        .idx  (ar_idx)
    );

    assign aw_fire = m_awvalid & m_awready;
    assign w_fire  = m_wvalid & m_wready;
    assign ar_fire = m_arvalid & m_arready;
    assign w_fwd   = (wr_state == W_FWD);
    // AW and W complete independently; each is done if already flagged or handshaking now.
    assign aw_now  = aw_done | s_awready[wsel];
    assign w_now   = w_done | w_fire;

    // awready is registered so it reads low out of reset and high whenever idle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state  <= W_IDLE;
            awaddr_q  <= '0;
            awprot_q  <= '0;
            wsel      <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awready_q <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        awaddr_q  <= m_awaddr;
                        awprot_q  <= m_awprot;
                        wsel      <= aw_idx;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        awready_q <= 1'b0;
                        wr_state  <= aw_hit ? W_FWD : W_ERRD;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_FWD: begin
                    aw_done <= aw_now;
                    w_done  <= w_now;
                    if (aw_now && w_now)
                        wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (m_bvalid && m_bready) begin
                        wr_state  <= W_IDLE;
                        awready_q <= 1'b1;
                    end
                end
                W_ERRD: begin
                    if (w_fire)
                        wr_state <= W_ERRB;
                end
                W_ERRB: begin
                    if (m_bready) begin
                        wr_state  <= W_IDLE;
                        awready_q <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state  <= R_IDLE;
            araddr_q  <= '0;
            arprot_q  <= '0;
            rsel      <= '0;
            arready_q <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        araddr_q  <= m_araddr;
                        arprot_q  <= m_arprot;
                        rsel      <= ar_idx;
                        arready_q <= 1'b0;
                        rd_state  <= ar_hit ? R_FWD : R_ERR;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_FWD: begin
                    if (s_arready[rsel])
                        rd_state <= R_RESP;
                end
                R_RESP: begin
                    if (m_rvalid && m_rready) begin
                        rd_state  <= R_IDLE;
                        arready_q <= 1'b1;
                    end
                end
                R_ERR: begin
                    if (m_rready) begin
                        rd_state  <= R_IDLE;
                        arready_q <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign wsel_oh = N'(1) << wsel;
    assign rsel_oh = N'(1) << rsel;

    // Address/prot are broadcast from the latches; only the selected slave ever sees a valid.
    assign s_awaddr  = {N{awaddr_q}};
    assign s_awprot  = {N{awprot_q}};
    assign s_araddr  = {N{araddr_q}};
    assign s_arprot  = {N{arprot_q}};
    assign s_wdata   = {N{m_wdata}};
    assign s_wstrb   = {N{m_wstrb}};
    assign s_awvalid = {N{w_fwd && !aw_done}} & wsel_oh;
    assign s_wvalid  = {N{w_fwd && !w_done && m_wvalid}} & wsel_oh;
    assign s_bready  = {N{(wr_state == W_RESP) && m_bready}} & wsel_oh;
    assign s_arvalid = {N{rd_state == R_FWD}} & rsel_oh;
    assign s_rready  = {N{(rd_state == R_RESP) && m_rready}} & rsel_oh;

    assign m_awready = awready_q;
    assign m_arready = arready_q;
    assign m_wready  = (w_fwd && !w_done) ? s_wready[wsel] : (wr_state == W_ERRD);
    assign m_bvalid  = (wr_state == W_RESP) ? s_bvalid[wsel] : (wr_state == W_ERRB);
    assign m_bresp   = (wr_state == W_RESP) ? s_bresp[wsel] :
                       (wr_state == W_ERRB) ? RESP_DECERR : RESP_OKAY;
    assign m_rvalid  = (rd_state == R_RESP) ? s_rvalid[rsel] : (rd_state == R_ERR);
    assign m_rdata   = (rd_state == R_RESP) ? s_rdata[rsel] : '0;
    assign m_rresp   = (rd_state == R_RESP) ? s_rresp[rsel] :
                       (rd_state == R_ERR)  ? RESP_DECERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_lite_demux.sv
// tb_axi_lite_demux: directed self-checking bench for axi_lite_demux with 4 slave windows.
module tb_axi_lite_demux;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [31:0]      m_awaddr = '0, m_wdata = '0, m_araddr = '0, m_rdata;
    logic [2:0]       m_awprot = '0, m_arprot = '0;
    logic [3:0]       m_wstrb = '0;
    logic             m_awvalid = 0, m_wvalid = 0, m_bready = 0, m_arvalid = 0, m_rready = 0;
    logic             m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [1:0]       m_bresp, m_rresp;
    logic [3:0][31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0][31:0] s_rdata = '0;
    logic [3:0][2:0]  s_awprot, s_arprot;
    logic [3:0][3:0]  s_wstrb;
    logic [3:0]       s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [3:0]       s_awready = '0, s_wready = '0, s_bvalid = '0, s_arready = '0, s_rvalid = '0;
    logic [3:0][1:0]  s_bresp = {4{2'b10}}, s_rresp = {4{2'b10}};
    int               errors = 0, checks = 0;

    always #5 aclk = ~aclk;

    axi_lite_demux #(
        .N        (4),
        .AW       (32),
        .DW       (32),
        .SLV_BASE ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK ({4{32'hF000_0000}})
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        tick; tick;
        checks++; if (m_awready !== 1'b0) begin errors++; $display("FAIL reset_awready: got %h want 0", m_awready); end
        checks++; if (m_arready !== 1'b0) begin errors++; $display("FAIL reset_arready: got %h want 0", m_arready); end
        checks++; if ({m_bvalid, m_rvalid, m_bresp, m_rresp} !== 6'b0) begin errors++; $display("FAIL reset_resp: got %h want 0", {m_bvalid, m_rvalid, m_bresp, m_rresp}); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
        checks++; if ({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready} !== 20'h0) begin errors++; $display("FAIL reset_slave_ctl: got %h want 0", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}); end
        checks++; if ({s_awaddr, s_araddr} !== '0) begin errors++; $display("FAIL reset_slave_addr: got %h want 0", {s_awaddr[0], s_araddr[0]}); end
        aresetn = 1'b1;
        tick;
        checks++; if ({m_awready, m_arready} !== 2'b11) begin errors++; $display("FAIL idle_ready: got %b want 11", {m_awready, m_arready}); end
    endtask

    task automatic test_write;
        m_awaddr = 32'h2000_0010; m_awprot = 3'b010; m_awvalid = 1; m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hF; m_wvalid = 1; m_bready = 1;
        tick;
        m_awvalid = 0; #1;
        checks++; if (s_awvalid !== 4'b0100) begin errors++; $display("FAIL wr_awvalid: got %b want 0100", s_awvalid); end
        checks++; if (s_awaddr[2] !== 32'h2000_0010 || s_awprot[2] !== 3'b010) begin errors++; $display("FAIL wr_awaddr: got %h/%h want 20000010/2", s_awaddr[2], s_awprot[2]); end
        checks++; if (s_wvalid !== 4'b0100 || s_wdata[2] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_wvalid: got %b/%h want 0100/deadbeef", s_wvalid, s_wdata[2]); end
        checks++; if ({m_awready, m_wready} !== 2'b00) begin errors++; $display("FAIL wr_m_ready: got %b want 00", {m_awready, m_wready}); end
        s_awready = 4'b0100;
        tick;
        s_awready = 4'b0000; #1;
        checks++; if (s_awvalid !== 4'b0000 || s_awaddr[2] !== 32'h2000_0010) begin errors++; $display("FAIL wr_aw_done: got %b/%h want 0000/20000010", s_awvalid, s_awaddr[2]); end
        s_wready = 4'b0100; #1;
        checks++; if (m_wready !== 1'b1) begin errors++; $display("FAIL wr_wready_pass: got %h want 1", m_wready); end
        tick;
        checks++; if (s_wvalid !== 4'b0000 || m_wready !== 1'b0) begin errors++; $display("FAIL wr_w_once: got %b/%h want 0000/0", s_wvalid, m_wready); end
        s_wready = 4'b0000; m_wvalid = 0; #1;
        checks++; if (m_bvalid !== 1'b0) begin errors++; $display("FAIL wr_b_early: got %h want 0", m_bvalid); end
        s_bvalid = 4'b0100; s_bresp[2] = 2'b00; #1;
        checks++; if ({m_bvalid, m_bresp} !== 3'b100 || s_bready !== 4'b0100) begin errors++; $display("FAIL wr_b: got %b/%b want 100/0100", {m_bvalid, m_bresp}, s_bready); end
        tick;
        s_bvalid = 4'b0000; s_bresp[2] = 2'b10; #1;
        checks++; if ({m_bvalid, m_awready} !== 2'b01) begin errors++; $display("FAIL wr_back_to_idle: got %b want 01", {m_bvalid, m_awready}); end
    endtask

    task automatic test_read_wait;
        m_araddr = 32'h1000_0004; m_arvalid = 1; m_rready = 1; s_rdata = {4{32'hFFFF_0000}};
        tick;
        m_arvalid = 0; #1;
        checks++; if (s_arvalid !== 4'b0010 || s_araddr[1] !== 32'h1000_0004) begin errors++; $display("FAIL rd_arvalid: got %b/%h want 0010/10000004", s_arvalid, s_araddr[1]); end
        s_arready = 4'b0010;
        tick;
        s_arready = 4'b0000; #1;
        checks++; if ({s_arvalid, m_rvalid} !== 5'b0) begin errors++; $display("FAIL rd_ar_done: got %b want 00000", {s_arvalid, m_rvalid}); end
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL rd_wait%0d: got %h want 0", i, m_rvalid); end
        end
        s_rvalid = 4'b0010; s_rdata[1] = 32'h1234_5678; s_rresp[1] = 2'b00; #1;
        checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h1234_5678 || m_rresp !== 2'b00) begin errors++; $display("FAIL rd_data: got %h/%h/%b want 1/12345678/00", m_rvalid, m_rdata, m_rresp); end
        checks++; if (s_rready !== 4'b0010) begin errors++; $display("FAIL rd_rready: got %b want 0010", s_rready); end
        tick;
        s_rvalid = 4'b0000; s_rresp[1] = 2'b10; #1;
        checks++; if ({m_rvalid, m_arready} !== 2'b01 || m_rdata !== 32'h0) begin errors++; $display("FAIL rd_back_to_idle: got %b/%h want 01/0", {m_rvalid, m_arready}, m_rdata); end
    endtask

    task automatic test_unmapped;
        m_araddr = 32'h8000_0000; m_arvalid = 1; m_rready = 0;
        tick;
        m_arvalid = 0; #1;
        checks++; if (s_arvalid !== 4'b0000) begin errors++; $display("FAIL err_rd_arvalid: got %b want 0000", s_arvalid); end
        checks++; if ({m_rvalid, m_rresp} !== 3'b111 || m_rdata !== 32'h0) begin errors++; $display("FAIL err_rd_resp: got %b/%h want 111/0", {m_rvalid, m_rresp}, m_rdata); end
        tick;
        checks++; if (m_rvalid !== 1'b1) begin errors++; $display("FAIL err_rd_hold: got %h want 1", m_rvalid); end
        m_rready = 1;
        tick;
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL err_rd_done: got %h want 0", m_rvalid); end
        m_awaddr = 32'h8000_0000; m_awvalid = 1; m_wdata = 32'h55; m_wvalid = 1; m_bready = 0;
        tick;
        m_awvalid = 0; #1;
        checks++; if (m_wready !== 1'b1 || {s_awvalid, s_wvalid} !== 8'h0) begin errors++; $display("FAIL err_wr_consume: got %h/%h want 1/00", m_wready, {s_awvalid, s_wvalid}); end
        tick;
        m_wvalid = 0; #1;
        checks++; if ({m_wready, m_bvalid, m_bresp} !== 4'b0111) begin errors++; $display("FAIL err_wr_b: got %b want 0111", {m_wready, m_bvalid, m_bresp}); end
        m_bready = 1;
        tick;
        checks++; if ({m_bvalid, m_awready} !== 2'b01) begin errors++; $display("FAIL err_wr_done: got %b want 01", {m_bvalid, m_awready}); end
    endtask

    task automatic test_concurrent;
        m_awaddr = 32'h0000_0100; m_awvalid = 1; m_wdata = 32'h0F0F_0F0F; m_wvalid = 1; m_bready = 1;
        m_araddr = 32'h3000_0008; m_arvalid = 1; m_rready = 1;
        s_awready = 4'b0001; s_wready = 4'b0001; s_arready = 4'b1000;
        tick;
        m_awvalid = 0; m_arvalid = 0; #1;
        checks++; if ({s_awvalid, s_wvalid, s_arvalid} !== 12'b0001_0001_1000) begin errors++; $display("FAIL cc_valids: got %b want 000100011000", {s_awvalid, s_wvalid, s_arvalid}); end
        tick;
        m_wvalid = 0; s_awready = 0; s_wready = 0; s_arready = 0;
        s_rvalid = 4'b1000; s_rdata[3] = 32'hCAFE_F00D; s_rresp[3] = 2'b00; #1;
        checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hCAFE_F00D || m_bvalid !== 1'b0) begin errors++; $display("FAIL cc_read: got %h/%h/%h want 1/cafef00d/0", m_rvalid, m_rdata, m_bvalid); end
        tick;
        s_rvalid = 0; s_rresp[3] = 2'b10; #1;
        checks++; if ({m_rvalid, m_arready, m_bvalid} !== 3'b010 || s_bready !== 4'b0001) begin errors++; $display("FAIL cc_read_done: got %b/%b want 010/0001", {m_rvalid, m_arready, m_bvalid}, s_bready); end
        tick; tick;
        s_bvalid = 4'b0001; s_bresp[0] = 2'b10; #1;
        checks++; if ({m_bvalid, m_bresp} !== 3'b110) begin errors++; $display("FAIL cc_slow_b: got %b want 110", {m_bvalid, m_bresp}); end
        tick;
        s_bvalid = 0; #1;
        checks++; if ({m_bvalid, m_awready} !== 2'b01) begin errors++; $display("FAIL cc_b_done: got %b want 01", {m_bvalid, m_awready}); end
    endtask

    task automatic test_w_early;
        m_awaddr = 32'h1000_0020; m_wdata = 32'hA5A5_5A5A; m_wvalid = 1; m_bready = 1;
        s_wready = 4'b0010; s_awready = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (m_wready !== 1'b0 || s_wvalid !== 4'b0000) begin errors++; $display("FAIL early_w_hold%0d: got %h/%b want 0/0000", i, m_wready, s_wvalid); end
        end
        m_awvalid = 1;
        tick;
        m_awvalid = 0; #1;
        checks++; if (m_wready !== 1'b1 || s_wvalid !== 4'b0010 || s_wdata[1] !== 32'hA5A5_5A5A) begin errors++; $display("FAIL early_w_fwd: got %h/%b/%h want 1/0010/a5a55a5a", m_wready, s_wvalid, s_wdata[1]); end
        tick;
        checks++; if (s_wvalid !== 4'b0000 || m_wready !== 1'b0) begin errors++; $display("FAIL early_w_once: got %b/%h want 0000/0", s_wvalid, m_wready); end
        m_wvalid = 0; s_wready = 0; s_awready = 0;
        s_bvalid = 4'b0010; s_bresp[1] = 2'b00; #1;
        checks++; if ({m_bvalid, m_bresp} !== 3'b100) begin errors++; $display("FAIL early_w_b: got %b want 100", {m_bvalid, m_bresp}); end
        tick;
        s_bvalid = 0; s_bresp[1] = 2'b10;
    endtask

    task automatic test_reset_mid;
        m_awaddr = 32'h2000_0000; m_awvalid = 1; m_wdata = 32'h77; m_wvalid = 1;
        m_araddr = 32'h1000_0000; m_arvalid = 1; m_rready = 0; s_arready = 4'b0010;
        tick;
        m_awvalid = 0; m_arvalid = 0;
        tick;
        s_arready = 0; s_rvalid = 4'b0010; s_rdata[1] = 32'h1111_2222; s_rresp[1] = 2'b00; #1;
        checks++; if (m_rvalid !== 1'b1 || s_awvalid !== 4'b0100) begin errors++; $display("FAIL mid_pre: got %h/%b want 1/0100", m_rvalid, s_awvalid); end
        aresetn = 0; #1;
        checks++; if ({m_rvalid, m_wready, m_awready, m_arready, m_bvalid} !== 5'b0 || m_rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_m: got %b/%h want 00000/0", {m_rvalid, m_wready, m_awready, m_arready, m_bvalid}, m_rdata); end
        checks++; if ({s_awvalid, s_wvalid, s_rready} !== 12'h0 || s_awaddr[2] !== 32'h0) begin errors++; $display("FAIL mid_rst_s: got %h/%h want 0/0", {s_awvalid, s_wvalid, s_rready}, s_awaddr[2]); end
        m_wvalid = 0; s_rvalid = 0;
        tick;
        aresetn = 1;
        tick;
        checks++; if ({m_awready, m_arready} !== 2'b11) begin errors++; $display("FAIL mid_idle: got %b want 11", {m_awready, m_arready}); end
        m_araddr = 32'h0000_0040; m_arvalid = 1; m_rready = 1; s_arready = 4'b0001;
        tick;
        m_arvalid = 0;
        tick;
        s_arready = 0; s_rvalid = 4'b0001; s_rdata[0] = 32'h0BAD_F00D; s_rresp[0] = 2'b00; #1;
        checks++; if ({m_rvalid, m_rresp} !== 3'b100 || m_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL mid_next_read: got %b/%h want 100/0badf00d", {m_rvalid, m_rresp}, m_rdata); end
        tick;
        s_rvalid = 0;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read_wait;
        test_unmapped;
        test_concurrent;
        test_w_early;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
